// File: rtl/sw_egress_arbiter.sv
// Packet-atomic round-robin arbiter merging two ingress FIFOs onto one egress port.
// Follows the 1-cycle registered FIFO read latency and emits a framed valid/ready stream.
module sw_egress_arbiter #(
    parameter int unsigned LEN_W = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             empty0,
    input  logic             empty1,
    input  logic [31:0]      dout0,
    input  logic [31:0]      dout1,
    output logic             rd_en0,
    output logic             rd_en1,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sop,
    output logic             out_eop,
    output logic [1:0]       grant,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1
);

    typedef enum logic [1:0] {StIdle, StHdr, StXfer} state_e;

    state_e           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic             rr_q, rr_d;
    logic [LEN_W-1:0] remain_q, remain_d;
    logic             pending_q, pending_d;
    logic [31:0]      data_q, data_d;
    logic             valid_q, valid_d;
    logic             sop_q, sop_d;
    logic             eop_q, eop_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic             slot_free;
    logic             owner_empty;
    logic [31:0]      owner_dout;
    logic [LEN_W-1:0] hdr_len;
    logic             winner;
    logic             pkt_done;

    assign slot_free   = !valid_q || out_ready;
    assign owner_dout  = grant_q[1] ? dout1 : dout0;
    assign owner_empty = grant_q[1] ? empty1 : empty0;
    assign hdr_len     = owner_dout[LEN_W-1:0];

    // rr_q holds the last winner; on a tie the other input is served.
    always_comb begin
        if (!empty0 && !empty1) begin
            winner = ~rr_q;
        end else begin
            winner = empty0;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        remain_d  = remain_q;
        pending_d = pending_q;
        data_d    = data_q;
        valid_d   = valid_q && !out_ready;
        sop_d     = sop_q;
        eop_d     = eop_q;
        rd_en0    = 1'b0;
        rd_en1    = 1'b0;
        pkt_done  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (slot_free && (!empty0 || !empty1)) begin
                    rd_en0  = !winner;
                    rd_en1  = winner;
                    grant_d = winner ? 2'b10 : 2'b01;
                    rr_d    = winner;
                    state_d = StHdr;
                end
            end
            StHdr: begin
                // Slot is guaranteed free here: the header read required it.
                data_d   = owner_dout;
                valid_d  = 1'b1;
                sop_d    = 1'b1;
                eop_d    = (hdr_len == '0);
                remain_d = hdr_len;
                if (hdr_len == '0) begin
                    pkt_done = 1'b1;
                    grant_d  = 2'b00;
                    state_d  = StIdle;
                end else begin
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (pending_q) begin
                    data_d    = owner_dout;
                    valid_d   = 1'b1;
                    sop_d     = 1'b0;
                    eop_d     = (remain_q == LEN_W'(1));
                    remain_d  = remain_q - LEN_W'(1);
                    pending_d = 1'b0;
                    if (remain_q == LEN_W'(1)) begin
                        pkt_done = 1'b1;
                        grant_d  = 2'b00;
                        state_d  = StIdle;
                    end
                end else if (remain_q != '0 && !owner_empty && slot_free) begin
                    rd_en0    = grant_q[0];
                    rd_en1    = grant_q[1];
                    pending_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (pkt_done && grant_q[0]) begin
            cnt0_d = cnt0_q + CNT_W'(1);
        end
        if (pkt_done && grant_q[1]) begin
            cnt1_d = cnt1_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= StIdle;
            grant_q   <= 2'b00;
            rr_q      <= 1'b1;
            remain_q  <= '0;
            pending_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            remain_q  <= remain_d;
            pending_q <= pending_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_sop   = sop_q;
    assign out_eop   = eop_q;
    assign grant     = grant_q;
    assign pkt_cnt0  = cnt0_q;
    assign pkt_cnt1  = cnt1_q;

endmodule

// File: tb/tb_sw_egress_arbiter.sv
// Scoreboard bench for sw_egress_arbiter: FIFO models feed the DUT, a monitor pops
// expected words on each output handshake.
module tb_sw_egress_arbiter;

    localparam int unsigned LEN_W = 8;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             resetN;
    logic             empty0, empty1;
    logic [31:0]      dout0, dout1;
    logic             rd_en0, rd_en1;
    logic [31:0]      out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_sop, out_eop;
    logic [1:0]       grant;
    logic [CNT_W-1:0] pkt_cnt0, pkt_cnt1;

    sw_egress_arbiter #(
        .LEN_W(LEN_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .resetN   (resetN),
        .empty0   (empty0),
        .empty1   (empty1),
        .dout0    (dout0),
        .dout1    (dout1),
        .rd_en0   (rd_en0),
        .rd_en1   (rd_en1),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sop  (out_sop),
        .out_eop  (out_eop),
        .grant    (grant),
        .pkt_cnt0 (pkt_cnt0),
        .pkt_cnt1 (pkt_cnt1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic        src;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          rd0_cnt = 0;
    int          rd1_cnt = 0;
    logic [1:0]  last_grant = 2'b00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // FIFO models with a registered 1-cycle read; pushes show up in empty a cycle later.
    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            q0.delete();
            q1.delete();
            dout0  <= 32'h0;
            dout1  <= 32'h0;
            empty0 <= 1'b1;
            empty1 <= 1'b1;
        end else begin
            if (rd_en0 && q0.size() > 0) dout0 <= q0.pop_front();
            if (rd_en1 && q1.size() > 0) dout1 <= q1.pop_front();
            empty0 <= (q0.size() == 0);
            empty1 <= (q1.size() == 0);
        end
    end

    always @(negedge clk) begin
        if (resetN) begin
            if (grant != 2'b00) last_grant = grant;
            if (rd_en0) rd0_cnt++;
            if (rd_en1) rd1_cnt++;
            check("rd_exclusive", 64'(rd_en0 & rd_en1), 64'd0);
            check("rd0_on_empty", 64'(rd_en0 & empty0), 64'd0);
            check("rd1_on_empty", 64'(rd_en1 & empty1), 64'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no word", out_data);
                end else begin
                    cur = exp_q.pop_front();
                    check("out_data", 64'(out_data), 64'(cur.data));
                    check("out_sop", 64'(out_sop), 64'(cur.sop));
                    check("out_eop", 64'(out_eop), 64'(cur.eop));
                    if (cur.sop) begin
                        check("sop_grant", 64'(last_grant), cur.src ? 64'd2 : 64'd1);
                    end
                end
            end
        end
    end

    task automatic expect_word(input logic [31:0] d, input logic s, input logic e,
                               input logic src);
        exp_q.push_back('{data: d, sop: s, eop: e, src: src});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        exp_q.delete();
        step(2);
        resetN = 1'b1;
        step(1);
    endtask

    task automatic drain(input string name, input int budget);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            step(1);
            i++;
        end
        check({name, "_drain_left"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        step(2);
    endtask

    initial begin
        int n;
        int base0;
        int base1;
        int sent0;
        int sent1;
        logic [31:0] h;

        resetN    = 1'b1;
        out_ready = 1'b1;
        #2;
        resetN = 1'b0;
        step(3);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_sop_eop", 64'({out_sop, out_eop}), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_cnts", 64'({pkt_cnt0, pkt_cnt1}), 64'd0);
        check("rst_rd_en", 64'({rd_en0, rd_en1}), 64'd0);
        resetN = 1'b1;
        step(2);

        // Single input, LEN=2
        base0 = rd0_cnt;
        base1 = rd1_cnt;
        q0.push_back(32'h0000_0002);
        q0.push_back(32'h0000_00A1);
        q0.push_back(32'h0000_00A2);
        expect_word(32'h0000_0002, 1'b1, 1'b0, 1'b0);
        expect_word(32'h0000_00A1, 1'b0, 1'b0, 1'b0);
        expect_word(32'h0000_00A2, 1'b0, 1'b1, 1'b0);
        n = 0;
        do begin @(negedge clk); n++; end while (!rd_en0 && n < 10);
        check("t1_rd_seen", 64'(rd_en0), 64'd1);
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 10);
        check("t1_hdr_latency", 64'(n), 64'd2);
        drain("t1", 50);
        check("t1_rd0_count", 64'(rd0_cnt - base0), 64'd3);
        check("t1_rd1_count", 64'(rd1_cnt - base1), 64'd0);
        check("t1_cnt0", 64'(pkt_cnt0), 64'd1);
        check("t1_cnt1", 64'(pkt_cnt1), 64'd0);

        // Tie after reset: input 0 first
        do_reset();
        q0.push_back(32'h0000_0100);
        q1.push_back(32'h0000_0200);
        expect_word(32'h0000_0100, 1'b1, 1'b1, 1'b0);
        expect_word(32'h0000_0200, 1'b1, 1'b1, 1'b1);
        drain("t2", 50);
        check("t2_cnt0", 64'(pkt_cnt0), 64'd1);
        check("t2_cnt1", 64'(pkt_cnt1), 64'd1);
        check("t2_grant_idle", 64'(grant), 64'd0);

        // Round-robin fairness over 8 LEN=1 packets with refilling
        do_reset();
        for (int k = 0; k < 4; k++) begin
            expect_word({8'h10, 8'(k), 16'h0001}, 1'b1, 1'b0, 1'b0);
            expect_word({8'hD0, 16'h0, 8'(k)}, 1'b0, 1'b1, 1'b0);
            expect_word({8'h20, 8'(k), 16'h0001}, 1'b1, 1'b0, 1'b1);
            expect_word({8'hE0, 16'h0, 8'(k)}, 1'b0, 1'b1, 1'b1);
        end
        sent0 = 0;
        sent1 = 0;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            if (sent0 < 4 && q0.size() <= 2) begin
                q0.push_back({8'h10, 8'(sent0), 16'h0001});
                q0.push_back({8'hD0, 16'h0, 8'(sent0)});
                sent0++;
            end
            if (sent1 < 4 && q1.size() <= 2) begin
                q1.push_back({8'h20, 8'(sent1), 16'h0001});
                q1.push_back({8'hE0, 16'h0, 8'(sent1)});
                sent1++;
            end
            step(1);
            n++;
        end
        drain("t3", 10);
        check("t3_cnt0", 64'(pkt_cnt0), 64'd4);
        check("t3_cnt1", 64'(pkt_cnt1), 64'd4);

        // Mid-packet starvation keeps grant on input 0
        do_reset();
        base1 = rd1_cnt;
        q0.push_back(32'h0000_0003);
        q0.push_back(32'h0000_00B1);
        q1.push_back(32'h0000_0300);
        expect_word(32'h0000_0003, 1'b1, 1'b0, 1'b0);
        expect_word(32'h0000_00B1, 1'b0, 1'b0, 1'b0);
        expect_word(32'h0000_00B2, 1'b0, 1'b0, 1'b0);
        expect_word(32'h0000_00B3, 1'b0, 1'b1, 1'b0);
        expect_word(32'h0000_0300, 1'b1, 1'b1, 1'b1);
        step(20);
        check("t4_grant_held", 64'(grant), 64'd1);
        check("t4_rd1_blocked", 64'(rd1_cnt - base1), 64'd0);
        check("t4_words_left", 64'(exp_q.size()), 64'd3);
        check("t4_cnt0_mid", 64'(pkt_cnt0), 64'd0);
        q0.push_back(32'h0000_00B2);
        q0.push_back(32'h0000_00B3);
        drain("t4", 60);
        check("t4_cnt0", 64'(pkt_cnt0), 64'd1);
        check("t4_cnt1", 64'(pkt_cnt1), 64'd1);
        check("t4_rd1_count", 64'(rd1_cnt - base1), 64'd1);

        // Backpressure on a valid header
        do_reset();
        out_ready = 1'b0;
        q0.push_back(32'h0000_5502);
        q0.push_back(32'h0000_00C1);
        q0.push_back(32'h0000_00C2);
        expect_word(32'h0000_5502, 1'b1, 1'b0, 1'b0);
        expect_word(32'h0000_00C1, 1'b0, 1'b0, 1'b0);
        expect_word(32'h0000_00C2, 1'b0, 1'b1, 1'b0);
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 10);
        check("t5_hdr_valid", 64'(out_valid), 64'd1);
        base0 = rd0_cnt;
        base1 = rd1_cnt;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t5_hold_data", 64'(out_data), 64'h5502);
            check("t5_hold_sop_valid", 64'({out_sop, out_valid}), 64'd3);
        end
        step(1);
        check("t5_no_rd", 64'((rd0_cnt - base0) + (rd1_cnt - base1)), 64'd0);
        out_ready = 1'b1;
        drain("t5", 60);
        check("t5_cnt0", 64'(pkt_cnt0), 64'd1);

        // Reset in the middle of a packet
        do_reset();
        q0.push_back(32'h0000_0003);
        q0.push_back(32'h0000_00E1);
        q0.push_back(32'h0000_00E2);
        q0.push_back(32'h0000_00E3);
        expect_word(32'h0000_0003, 1'b1, 1'b0, 1'b0);
        expect_word(32'h0000_00E1, 1'b0, 1'b0, 1'b0);
        expect_word(32'h0000_00E2, 1'b0, 1'b0, 1'b0);
        expect_word(32'h0000_00E3, 1'b0, 1'b1, 1'b0);
        n = 0;
        while (exp_q.size() > 2 && n < 50) begin
            step(1);
            n++;
        end
        check("t6_partial", 64'(exp_q.size()), 64'd2);
        resetN = 1'b0;
        #1;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_data", 64'(out_data), 64'd0);
        check("t6_rst_sop_eop", 64'({out_sop, out_eop}), 64'd0);
        check("t6_rst_grant", 64'(grant), 64'd0);
        check("t6_rst_rd_en", 64'({rd_en0, rd_en1}), 64'd0);
        exp_q.delete();
        step(2);
        resetN = 1'b1;
        step(1);
        h = 32'h0000_0701;
        q1.push_back(h);
        q1.push_back(32'h0000_00F1);
        expect_word(h, 1'b1, 1'b0, 1'b1);
        expect_word(32'h0000_00F1, 1'b0, 1'b1, 1'b1);
        drain("t6", 50);
        check("t6_cnt1", 64'(pkt_cnt1), 64'd1);
        check("t6_cnt0", 64'(pkt_cnt0), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1);
    end

endmodule

// File: doc/sw_egress_arbiter.md
# sw_egress_arbiter

Packet-atomic round-robin arbiter that shares one switch egress port between the two ingress 32x4 FIFOs (ports 0 and 1) targeting it. It drives each FIFO's read enable, follows the 1-cycle registered FIFO read latency, and presents a framed word stream (valid/ready, sop/eop) to the egress MAC side. One instance sits in front of each of the two egress ports of the 2x2 switch.

## Interface
- Parameters:
- LEN_W, default 8: width of the header length field and of the remaining-word counter.
- CNT_W, default 16: width of the per-input packet counters.
- Ports:
- clk  in  1  clock; all logic on the rising edge.
- resetN  in  1  asynchronous, active-low reset.
- empty0, empty1  in  1 each  empty flag of ingress FIFO 0 / 1.
- dout0, dout1  in  32 each  FIFO read data; valid the cycle after rd_en.
- rd_en0, rd_en1  out  1 each  FIFO read enable; combinational from registered state plus inputs; never both high.
- out_data  out  32  egress word.
- out_valid  out  1  out_data/out_sop/out_eop valid.
- out_ready  in  1  egress sink accepts the word when out_valid && out_ready.
- out_sop, out_eop  out  1 each  first / last word of packet.
- grant  out  2  one-hot current owner; 00 when idle.
- pkt_cnt0, pkt_cnt1  out  CNT_W each  packets forwarded from input 0 / 1, wrap modulo 2^CNT_W.

## Operation
- Packet format: first word is the header; header[LEN_W-1:0] = LEN = number of payload words following it (0..255). Packet = LEN+1 words. The header is forwarded unchanged.
- State machine: IDLE, HDR, XFER.
- Output slot free: slot_free = !out_valid || out_ready.
- IDLE: if slot_free and at least one FIFO non-empty, pick winner; assert winner's rd_en this cycle; grant <= winner; state -> HDR. Both non-empty: winner is the input not served last (rr pointer). rr pointer resets to 1 (input 0 wins the first tie) and updates to the winner at each grant.
- HDR (cycle after the header read): capture dout of owner into out_data, out_valid=1, out_sop=1, out_eop=(LEN==0); remain <= LEN. LEN==0 -> IDLE, else XFER.
- XFER: pending flag set in the cycle rd_en is asserted, cleared next cycle when the word is loaded into the output register. rd_en(owner) asserted when remain>0 && !pending && !empty(owner) && slot_free. On load: out_sop=0, out_eop=(remain==1), remain decrements. After the load of the eop word -> IDLE.
- Packet atomicity: an owner keeps grant while its FIFO runs empty mid-packet; the other input is never served until eop is loaded.
- pkt_cntN increments by 1 in the cycle its eop word is loaded into the output register.
- Output register holds out_data/sop/eop/valid unchanged while out_valid && !out_ready. out_valid clears on handshake when no new word loads in the same cycle.
- rd_en is never asserted for an empty FIFO and never while a read is pending.

## Timing
- Reset (async, any state): state IDLE, grant 00, rr=1, remain 0, pending 0, out_valid 0, out_sop 0, out_eop 0, out_data 0, pkt_cnt0/1 0, rd_en0/1 0. Reset mid-packet abandons the partial packet; the FIFOs are reset by the same resetN.
- Header latency: rd_en in cycle T (IDLE), header on out_data with out_valid from cycle T+2.
- Throughput: at most one word per 2 cycles (read cycle + load cycle); payload word k of a packet loads no earlier than 2k cycles after the header load.
- Back-to-back packets: IDLE is entered the cycle after the eop load; next header read may issue that cycle if slot_free.
- Backpressure: out_ready low stalls new reads (slot not free); no word is lost or duplicated.

## Test plan
- Single input: FIFO0 holds header LEN=2 (0x0000_0002), payload 0xA1, 0xA2; out_ready=1 -> rd_en0 three times, out words 0x2(sop),0xA1,0xA2(eop), grant=01, pkt_cnt0=1, rd_en1 never high.
- Tie after reset: both FIFOs hold LEN=0 headers 0x100, 0x200 -> outputs 0x100 (sop,eop) then 0x200 (sop,eop); grant 01 then 10; both counters 1.
- Round-robin fairness: both FIFOs continuously refilled with LEN=1 packets for 8 packets -> strict alternation 0,1,0,1...; pkt_cnt0=pkt_cnt1=4.
- Mid-packet starvation: FIFO0 header LEN=3 with only 1 payload word, FIFO1 non-empty -> grant stays 01, rd_en1 stays 0 until remaining 2 words arrive, then eop, then FIFO1 served.
- Backpressure: out_ready held 0 for 5 cycles while header is valid -> out_data/sop stable, no rd_en asserted; on release stream completes intact.
- Reset mid-packet: assert resetN=0 during XFER -> all outputs 0 immediately; after release, new packet on FIFO1 forwarded with sop and grant=10.
